float_sign_unit: RTL and testbench
==================================

Name: float_sign_unit

Overview:
- Parametrised, pipelined IEEE-754 sign-manipulation unit; successor to the fixed 64-bit, free-running negate block.
- Supports four per-operation modes: pass, negate, absolute value and copysign.
- Uses valid/ready handshakes on input and output, with full backpressure.
- Sits between float arithmetic stages in the math component library; any IEEE binary format is selected by parameters.

Parameters:
- WIDTH, 64, total float width; sign bit is WIDTH-1.
- EXP_BITS, 11, exponent field width; mantissa is WIDTH-1-EXP_BITS bits.
- STAGES, 2, pipeline depth in registers; legal range 1..8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_a  input  WIDTH  operand A (magnitude source).
- in_b  input  WIDTH  operand B (sign source, copysign mode only).
- in_mode  input  2  operation: 0 pass, 1 neg, 2 abs, 3 copysign.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- out_z  output  WIDTH  result.
- out_nan  output  1  result is NaN.
- out_zero  output  1  result is ±0.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset: sampled on a clk edge with rst=1. All stage valid bits, out_valid, out_z, out_nan and out_zero clear to 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats; no partial beat is emitted.
- Arithmetic, applied to in_a (bit-level only; NaNs are never quieted and the payload is preserved):
  - mode 0: z = a.
  - mode 1: z = {~a[W-1], a[W-2:0]}.
  - mode 2: z = {1'b0, a[W-2:0]}.
  - mode 3: z = {b[W-1], a[W-2:0]}.
- Flags are computed on z:
  - out_nan = exponent all ones AND mantissa != 0.
  - out_zero = exponent and mantissa both zero, for either sign.
  - Infinity sets neither flag.
  - Denormals are treated as ordinary values.
- Pipeline:
  - STAGES register slices, each holding {valid, z, nan, zero}. The computation is done before slice 0; later slices only transport data.
  - advance = !out_valid OR out_ready. When advance=1 every slice shifts forward one position. When advance=0 all slices hold.
  - in_ready = advance (combinational from out_valid and out_ready only; no path from in_valid).
  - A beat is accepted when in_valid AND in_ready. A slot shifted in without acceptance gets valid=0 (bubble).
  - out_valid and out_z come from the last slice.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready is held at 1.
- Throughput: one beat per cycle when out_ready=1. Ordering is strictly preserved.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_z, out_nan and out_zero are stable.
  - Bubbles are not collapsed during a stall; the whole pipe freezes.
- Simultaneous events:
  - The output transfer and input accept occur in the same cycle whenever out_ready=1.
  - rst overrides all handshakes.
- in_mode and in_b are ignored when in_valid=0. in_b is ignored in modes 0-2.

Test Plan:
- Reset, WIDTH=64, STAGES=2: hold rst=1 for 3 cycles with in_valid=1 -> out_valid=0 throughout. After release, in_ready=1 and out_valid stays 0 until a beat is accepted.
- Modes, out_ready=1:
  - a=0x3FF0000000000000 (1.0), mode 1 -> out_z=0xBFF0000000000000 exactly 2 cycles after accept.
  - a=0xC000000000000000, mode 2 -> 0x4000000000000000.
  - a=0x4000000000000000, b=0x8000000000000001, mode 3 -> 0xC000000000000000.
  - a=0x4000000000000000, mode 0 -> 0x4000000000000000.
- Flags:
  - a=0x7FF8000000000001, mode 1 -> z=0xFFF8000000000001, out_nan=1.
  - a=0x0000000000000000, mode 1 -> z=0x8000000000000000, out_zero=1.
  - a=0x7FF0000000000000 -> out_nan=0, out_zero=0.
- Backpressure: stream 10 beats (a = 1..10, mode 1); deassert out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, out_z held stable, all 10 results emitted in order with MSB set and none lost or duplicated.
- Full throughput: 100 random beats with in_valid=1 and out_ready=1 continuously -> 100 outputs on consecutive cycles, each matching a reference model.
- Parameter sweep: WIDTH=32, EXP_BITS=8, STAGES=1; a=0x3F800000, mode 1 -> 0xBF800000 after 1 cycle; a=0x7FC00000 -> out_nan=1. Assert rst mid-stream -> next out_valid only after a new accept.

Source files
------------

// File: rtl/float_sign_unit.sv
// Pipelined IEEE-754 sign manipulation: pass, negate, abs, copysign, plus NaN/zero flags.
// Valid/ready on both sides; the whole pipe advances or freezes as one.
module float_sign_unit #(
  parameter int WIDTH    = 64,
  parameter int EXP_BITS = 11,
  parameter int STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_nan,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int MANT_BITS = WIDTH - 1 - EXP_BITS;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_NEG  = 2'd1;
  localparam logic [1:0] MODE_ABS  = 2'd2;

  logic                         advance;
  logic                         sign_calc;
  logic [WIDTH-1:0]             z_calc;
  logic [EXP_BITS-1:0]          exp_calc;
  logic [MANT_BITS-1:0]         mant_calc;
  logic                         nan_calc;
  logic                         zero_calc;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] z_q, z_d;
  logic [STAGES-1:0]            nan_q, nan_d;
  logic [STAGES-1:0]            zero_q, zero_d;

  // Only the sign bit of operand B is ever consulted.
  logic unused_b_bits;
  assign unused_b_bits = ^in_b[WIDTH-2:0];

  // Handshake: a beat moves on a rising edge when valid && ready on that side.
  // in_ready depends only on the output side so no combinational loop forms
  // through an upstream producer that looks at in_ready before raising in_valid.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    sign_calc = in_b[WIDTH-1];
    case (in_mode)
      MODE_PASS: sign_calc = in_a[WIDTH-1];
      MODE_NEG:  sign_calc = ~in_a[WIDTH-1];
      MODE_ABS:  sign_calc = 1'b0;
      default:   sign_calc = in_b[WIDTH-1];
    endcase
    z_calc    = {sign_calc, in_a[WIDTH-2:0]};
    exp_calc  = z_calc[WIDTH-2 -: EXP_BITS];
    mant_calc = z_calc[MANT_BITS-1:0];
    nan_calc  = (&exp_calc) && (|mant_calc);
    zero_calc = (z_calc[WIDTH-2:0] == '0);
  end

  // Slice 0 takes the freshly computed result; a cycle that advances without
  // an accepted beat inserts a bubble rather than collapsing existing ones.
  always_comb begin
    valid_d = valid_q;
    z_d     = z_q;
    nan_d   = nan_q;
    zero_d  = zero_q;
    if (advance) begin
      valid_d[0] = in_valid;
      z_d[0]     = z_calc;
      nan_d[0]   = nan_calc;
      zero_d[0]  = zero_calc;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        z_d[i]     = z_q[i-1];
        nan_d[i]   = nan_q[i-1];
        zero_d[i]  = zero_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      z_q     <= '0;
      nan_q   <= '0;
      zero_q  <= '0;
    end else begin
      valid_q <= valid_d;
      z_q     <= z_d;
      nan_q   <= nan_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_z     = z_q[STAGES-1];
  assign out_nan   = nan_q[STAGES-1];
  assign out_zero  = zero_q[STAGES-1];

endmodule

// File: tb/tb_float_sign_unit.sv
// Bench for float_sign_unit: a 64-bit/2-stage instance and a 32-bit/1-stage instance,
// table vectors plus directed latency, backpressure, throughput and reset sequences.
module tb_float_sign_unit;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  mode;
    logic [63:0] z;
    logic        nan;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;

  logic [63:0] in_a, in_b, out_z;
  logic [1:0]  in_mode;
  logic        in_valid, in_ready, out_nan, out_zero, out_valid, out_ready;

  logic [31:0] in_a_s, in_b_s, out_z_s;
  logic [1:0]  in_mode_s;
  logic        in_valid_s, in_ready_s, out_nan_s, out_zero_s, out_valid_s, out_ready_s;

  logic [65:0] exp_q[$];
  logic [33:0] exp_q_s[$];
  logic [65:0] e64;
  logic [33:0] e32;
  logic [63:0] held;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int consec = 0;
  int last_pop = -10;
  int pop0, consec0;

  vec_t vecs[11];

  float_sign_unit #(.WIDTH(64), .EXP_BITS(11), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .out_z(out_z), .out_nan(out_nan),
    .out_zero(out_zero), .out_valid(out_valid), .out_ready(out_ready)
  );

  float_sign_unit #(.WIDTH(32), .EXP_BITS(8), .STAGES(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_a(in_a_s), .in_b(in_b_s), .in_mode(in_mode_s),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .out_z(out_z_s), .out_nan(out_nan_s),
    .out_zero(out_zero_s), .out_valid(out_valid_s), .out_ready(out_ready_s)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] m);
    logic        s;
    logic [63:0] z;
    case (m)
      2'd0:    s = a[63];
      2'd1:    s = !a[63];
      2'd2:    s = 1'b0;
      default: s = b[63];
    endcase
    z = {s, a[62:0]};
    return {z, (z[62:52] == 11'h7FF) && (z[51:0] != 52'd0), z[62:0] == 63'd0};
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
    logic        s;
    logic [31:0] z;
    case (m)
      2'd0:    s = a[31];
      2'd1:    s = !a[31];
      2'd2:    s = 1'b0;
      default: s = b[31];
    endcase
    z = {s, a[30:0]};
    return {z, (z[30:23] == 8'hFF) && (z[22:0] != 23'd0), z[30:0] == 31'd0};
  endfunction

  // Scoreboard: pop and compare on each output transfer, flush on reset.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_q_s.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out64_extra: got %h expected no beat", out_z);
        end else begin
          e64 = exp_q.pop_front();
          check("out64", {out_z, out_nan, out_zero}, e64);
        end
        if (cyc == last_pop + 1) consec++;
        last_pop = cyc;
        pop_cnt++;
      end
      if (out_valid_s && out_ready_s) begin
        if (exp_q_s.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out32_extra: got %h expected no beat", out_z_s);
        end else begin
          e32 = exp_q_s.pop_front();
          check("out32", 66'({out_z_s, out_nan_s, out_zero_s}), 66'(e32));
        end
      end
    end
  end

  // Driver tasks: called just after a rising edge, return just after the accepting edge.
  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                        input logic [65:0] e);
    int k;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send64_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [33:0] e);
    int k;
    in_a_s = a; in_b_s = b; in_mode_s = m; in_valid_s = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready_s && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send32_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q_s.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50 && (exp_q.size() != 0 || exp_q_s.size() != 0); k++)
      @(negedge clk);
    check(name, 66'(exp_q.size() + exp_q_s.size()), 66'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rm;
    logic [31:0] sa, sb;

    vecs[0]  = '{64'h3FF0000000000000, 64'h0, 2'd1, 64'hBFF0000000000000, 1'b0, 1'b0};
    vecs[1]  = '{64'hC000000000000000, 64'h0, 2'd2, 64'h4000000000000000, 1'b0, 1'b0};
    vecs[2]  = '{64'h4000000000000000, 64'h8000000000000001, 2'd3, 64'hC000000000000000, 1'b0, 1'b0};
    vecs[3]  = '{64'h4000000000000000, 64'h0, 2'd0, 64'h4000000000000000, 1'b0, 1'b0};
    vecs[4]  = '{64'h7FF8000000000001, 64'h0, 2'd1, 64'hFFF8000000000001, 1'b1, 1'b0};
    vecs[5]  = '{64'h0000000000000000, 64'h0, 2'd1, 64'h8000000000000000, 1'b0, 1'b1};
    vecs[6]  = '{64'h7FF0000000000000, 64'h0, 2'd0, 64'h7FF0000000000000, 1'b0, 1'b0};
    vecs[7]  = '{64'hFFF0000000000001, 64'h0, 2'd2, 64'h7FF0000000000001, 1'b1, 1'b0};
    vecs[8]  = '{64'h8000000000000000, 64'h0, 2'd2, 64'h0000000000000000, 1'b0, 1'b1};
    vecs[9]  = '{64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 2'd3, 64'h8000000000000001, 1'b0, 1'b0};
    vecs[10] = '{64'h0000000000000001, 64'h8000000000000000, 2'd0, 64'h0000000000000001, 1'b0, 1'b0};

    rst = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0; in_valid = 1'b1; out_ready = 1'b1;
    in_a_s = '0; in_b_s = '0; in_mode_s = '0; in_valid_s = 1'b0; out_ready_s = 1'b1;

    // Reset held with in_valid high: nothing may emerge
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("rst_out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out", {out_z, out_nan, out_zero}, 66'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("idle_out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Two-cycle latency from accept
    in_a = 64'h3FF0000000000000; in_b = '0; in_mode = 2'd1; in_valid = 1'b1;
    @(negedge clk);
    check_bit("lat_in_ready", in_ready, 1'b1);
    exp_q.push_back({64'hBFF0000000000000, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("lat_early", out_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_hit", out_valid, 1'b1);
    @(posedge clk);
    #1;

    // Table vectors, back to back
    for (int i = 0; i < 11; i++)
      send64(vecs[i].a, vecs[i].b, vecs[i].mode, {vecs[i].z, vecs[i].nan, vecs[i].zero});
    drain("drain_table");

    // Backpressure: 4-cycle stall in the middle of a 10-beat stream
    fork
      begin
        for (int i = 1; i <= 10; i++)
          send64(64'(i), 64'h0, 2'd1, {64'h8000000000000000 | 64'(i), 1'b0, 1'b0});
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) held = out_z;
          else check("stall_z_stable", 66'(out_z), 66'(held));
          check_bit("stall_in_ready", in_ready, 1'b0);
          check_bit("stall_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");
    repeat (3) @(posedge clk);
    #1;

    // Full throughput against the reference model
    pop0 = pop_cnt;
    consec0 = consec;
    for (int i = 0; i < 100; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra[62:0] = '0;
        1: ra[62:52] = '1;
        2: begin ra[62:52] = '1; ra[51:0] = '0; end
        default: ;
      endcase
      send64(ra, rb, rm, model64(ra, rb, rm));
    end
    drain("drain_rand");
    check("tput_count", 66'(pop_cnt - pop0), 66'd100);
    check("tput_consec", 66'(consec - consec0), 66'd99);

    // Narrow format, single stage
    in_a_s = 32'h3F800000; in_b_s = '0; in_mode_s = 2'd1; in_valid_s = 1'b1;
    @(negedge clk);
    check_bit("lat32_in_ready", in_ready_s, 1'b1);
    exp_q_s.push_back({32'hBF800000, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    @(negedge clk);
    check_bit("lat32_hit", out_valid_s, 1'b1);
    @(posedge clk);
    #1;
    send32(32'h7FC00000, 32'h0, 2'd0, {32'h7FC00000, 1'b1, 1'b0});
    send32(32'hBF800000, 32'h0, 2'd2, {32'h3F800000, 1'b0, 1'b0});
    send32(32'h80000000, 32'h0, 2'd0, {32'h80000000, 1'b0, 1'b1});
    send32(32'h7F800000, 32'h0, 2'd1, {32'hFF800000, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++) begin
      sa = $urandom();
      sb = $urandom();
      rm = 2'($urandom_range(0, 3));
      if (i % 4 == 0) sa[30:23] = '1;
      send32(sa, sb, rm, model32(sa, sb, rm));
    end
    drain("drain32");

    // Reset with a beat stuck in the stalled pipe: it must vanish
    out_ready_s = 1'b0;
    in_a_s = 32'h12345678; in_mode_s = 2'd0; in_valid_s = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
    @(negedge clk);
    check_bit("held32_valid", out_valid_s, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("rst32_out_valid", out_valid_s, 1'b0);
    end
    @(posedge clk);
    #1;
    send32(32'h40490FDB, 32'h80000000, 2'd3, {32'hC0490FDB, 1'b0, 1'b0});
    drain("drain32_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
